// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared definitions for the data-memory access path.
//   - RISC-V load/store funct3 encodings
//   - state encoding for the misaligned-access split FSM
//   - helpers deciding whether an access is misaligned and how long its split is
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        StIdle,
        StSplit
    } split_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=00. Byte and the
    // reserved size 11 are passed through untouched.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic result;
        result = 1'b0;
        case (funct3[1:0])
            2'b01:   result = addr_lo[0];
            2'b10:   result = (addr_lo != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Index of the final byte of a split: 1 for a halfword, 3 for a word.
    function automatic logic [1:0] split_last_idx(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b10) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend: combinational sign/zero extension of load data.
//   funct3_i[1:0] selects size (00 byte, 01 halfword, others word as-is);
//   funct3_i[2]=1 selects zero extension.
// Ports:
//   funct3_i  RISC-V load funct3
//   data_i    raw load data, value in the low bytes
//   data_o    extended result
// ---------------------------------------------------------------------------
module load_extend
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic sign_b;
    logic sign_h;

    always_comb begin
        sign_b = ~funct3_i[2] & data_i[7];
        sign_h = ~funct3_i[2] & data_i[15];
        data_o = data_i;
        case (funct3_i[1:0])
            2'b00:   data_o = {{(DATA_WIDTH-8){sign_b}}, data_i[7:0]};
            2'b01:   data_o = {{(DATA_WIDTH-16){sign_h}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// ---------------------------------------------------------------------------
// mem_align_unit: MEM-stage alignment front end for the data memory.
//   Aligned accesses pass straight through combinationally. Misaligned
//   halfword/word accesses are split into N sequential byte accesses
//   (N=2 halfword, N=4 word) while the pipeline is stalled; load bytes are
//   gathered into an assembly register and extended on the final cycle.
//   With ALLOW_MISALIGNED=0 a misaligned access is suppressed and flagged.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_write    access present / store(1) or load(0)
//   req_funct3/addr/wdata  access description from EX/MEM
//   stall                  hold the upstream pipeline
//   load_data              extended load result to MEM/WB
//   misaligned             suppressed misaligned access
//   mem_wr_en/addr/wdata/funct3  data memory request
//   mem_rd_data            combinational data memory read data
// ---------------------------------------------------------------------------
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    split_state_e          state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;

    logic                  req_mis;
    logic                  split_go;
    logic [1:0]            last_k;
    logic [1:0]            cur_k;
    logic                  issue;
    logic                  last_byte;
    logic [4:0]            byte_sel;
    logic [4:0]            last_sel;
    logic [7:0]            wbyte;
    logic [DATA_WIDTH-1:0] asm_full;
    logic [DATA_WIDTH-1:0] ext_data;

    // ------------------------------------------------------------------
    // Request decode and current byte selection
    // ------------------------------------------------------------------
    always_comb begin
        req_mis  = req_valid & is_misaligned(req_funct3, req_addr[1:0]);
        last_k   = split_last_idx(req_funct3);
        // Byte 0 of a split is issued from IDLE in the same cycle.
        split_go = ALLOW_MISALIGNED & req_mis & ~reset;

        cur_k = 2'd0;
        issue = 1'b0;
        if (state_q == StSplit) begin
            cur_k = k_q;
            // A dropped req_valid is a flush: nothing more goes to memory.
            issue = req_valid & ~reset;
        end else begin
            cur_k = 2'd0;
            issue = split_go;
        end

        last_byte = (cur_k == last_k);
        byte_sel  = {cur_k, 3'b000};
        last_sel  = {last_k, 3'b000};
        wbyte     = req_wdata[byte_sel +: 8];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            asm_q   <= asm_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        asm_d   = asm_q;

        case (state_q)
            StIdle: begin
                if (split_go) begin
                    state_d = StSplit;
                    k_d     = 2'd1;
                end
            end
            StSplit: begin
                if (!req_valid || last_byte) begin
                    state_d = StIdle;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = 2'd0;
            end
        endcase

        // The last byte is never stored; it is merged directly from memory.
        if (issue && !req_write && !last_byte) begin
            asm_d[byte_sel +: 8] = mem_rd_data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Load reassembly and extension
    // ------------------------------------------------------------------
    always_comb begin
        asm_full                = asm_q;
        asm_full[last_sel +: 8] = mem_rd_data[7:0];
    end

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .funct3_i (req_funct3),
        .data_i   (asm_full),
        .data_o   (ext_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
        mem_funct3 = req_funct3;
        mem_wr_en  = req_valid & req_write & ~reset;
        stall      = 1'b0;
        misaligned = 1'b0;
        load_data  = mem_rd_data;

        if (state_q == StSplit || req_mis) begin
            if (!ALLOW_MISALIGNED) begin
                mem_wr_en  = 1'b0;
                misaligned = ~reset;
                load_data  = '0;
            end else begin
                mem_addr   = req_addr + ADDR_WIDTH'(cur_k);
                mem_funct3 = req_write ? F3_B : F3_BU;
                mem_wdata  = {{(DATA_WIDTH-8){1'b0}}, wbyte};
                mem_wr_en  = issue & req_write;
                stall      = issue & ~last_byte;
                load_data  = ext_data;
            end
        end
    end

endmodule
